spi_arb: RTL

SPI_ARB -- requirements
Module: spi_arb

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_rr2.sv | 47 ++++
 rtl/spi_arb.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// ============================================================================
//  Module   : spi_pkg
//  Purpose  : Shared constants for the SPI arbiter: default parameters,
//             timeout counter width and FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  // Default SPI word width and wait-state timeout (cycles)
  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_TIMEOUT = 255;

  // Timeout counter is wide enough for the largest legal TIMEOUT (65535)
  localparam int CNT_W = 16;

  // Arbiter FSM encoding; CAPTURE spans two states (read strobe, then rvalid)
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_CAPTURE   = 3'd4;
  localparam logic [2:0] ST_CAP_RV    = 3'd5;
  localparam logic [2:0] ST_ABORT     = 3'd6;

endpackage

`default_nettype wire

// File: rtl/spi_rr2.sv
// ============================================================================
//  Module   : spi_rr2
//  Purpose  : Two-input combinational round-robin selector. A lone request
//             always wins; on contention the requester named by i_prio wins.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_rr2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_gnt,
  output logic       o_idx
);

  // Pick one requester, one-hot grant plus its index
  always_comb begin
    o_gnt = 2'b00;
    o_idx = 1'b0;
    case (i_req)
      2'b01: begin
        o_gnt = 2'b01;
        o_idx = 1'b0;
      end
      2'b10: begin
        o_gnt = 2'b10;
        o_idx = 1'b1;
      end
      2'b11: begin
        if (i_prio) begin
          o_gnt = 2'b10;
          o_idx = 1'b1;
        end else begin
          o_gnt = 2'b01;
          o_idx = 1'b0;
        end
      end
      default: begin
        o_gnt = 2'b00;
        o_idx = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/spi_arb.sv
// ============================================================================
//  Module   : spi_arb
//  Purpose  : Two-requester round-robin arbiter in front of a single SPI
//             core. Issues one write per transaction, waits for the core to
//             go busy and then idle again (each wait bounded by TIMEOUT),
//             reads the received word back and returns it to the winner.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_arb
  import spi_pkg::*;
#(
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic [1:0]        gnt,
  output logic [DWIDTH-1:0] rdata,
  output logic [1:0]        rvalid,
  output logic [1:0]        err,
  output logic              spi_cs,
  output logic              spi_wr,
  output logic              spi_rd,
  output logic [DWIDTH-1:0] spi_din,
  input  logic [DWIDTH-1:0] spi_dout,
  input  logic              spi_done
);

  localparam logic [CNT_W-1:0] c_timeout_load = CNT_W'(TIMEOUT);

  logic [2:0]        r_state;
  logic [1:0]        r_gnt;
  logic              r_gidx;   // index of the current winner
  logic              r_prio;   // requester favoured on the next contention
  logic [CNT_W-1:0]  r_cnt;
  logic [DWIDTH-1:0] r_din;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_ready;  // blocks a grant on the first edge after reset

  logic [1:0]        w_rr_gnt;
  logic              w_rr_idx;
  logic [CNT_W-1:0]  w_cnt_dec;

  spi_rr2 u_rr (
    .i_req  (req),
    .i_prio (r_prio),
    .o_gnt  (w_rr_gnt),
    .o_idx  (w_rr_idx)
  );

  assign w_cnt_dec = r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};

  // Transaction sequencer: grant, issue, bounded waits, capture or abort
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= 2'b00;
      r_gidx  <= 1'b0;
      r_prio  <= 1'b0;
      r_cnt   <= '0;
      r_din   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_ready && spi_done && (req != 2'b00)) begin
            r_gnt   <= w_rr_gnt;
            r_gidx  <= w_rr_idx;
            r_din   <= w_rr_idx ? wdata1 : wdata0;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // The write is only strobed while the core is idle; a core that
          // went busy on its own is treated as a failed transaction.
          if (spi_done) begin
            r_cnt   <= c_timeout_load;
            r_state <= ST_WAIT_BUSY;
          end else begin
            r_state <= ST_ABORT;
          end
        end
        ST_WAIT_BUSY: begin
          if (!spi_done) begin
            r_cnt   <= c_timeout_load;
            r_state <= ST_WAIT_DONE;
          end else begin
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec == '0) begin
              r_state <= ST_ABORT;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (spi_done) begin
            r_state <= ST_CAPTURE;
          end else begin
            r_cnt <= w_cnt_dec;
            if (w_cnt_dec == '0) begin
              r_state <= ST_ABORT;
            end
          end
        end
        ST_CAPTURE: begin
          r_rdata <= spi_dout;
          r_state <= ST_CAP_RV;
        end
        ST_CAP_RV: begin
          r_gnt   <= 2'b00;
          r_prio  <= ~r_gidx;
          r_state <= ST_IDLE;
        end
        ST_ABORT: begin
          r_gnt   <= 2'b00;
          r_prio  <= ~r_gidx;
          r_state <= ST_IDLE;
        end
        default: begin
          r_gnt   <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Strobes and pulses decode straight from state so reset clears them at once
  assign gnt     = r_gnt;
  assign spi_din = r_din;
  assign rdata   = r_rdata;
  assign spi_cs  = (r_state == ST_ISSUE) && spi_done;
  assign spi_wr  = (r_state == ST_ISSUE) && spi_done;
  assign spi_rd  = (r_state == ST_CAPTURE);
  assign rvalid  = (r_state == ST_CAP_RV) ? r_gnt : 2'b00;
  assign err     = (r_state == ST_ABORT)  ? r_gnt : 2'b00;

endmodule

`default_nettype wire
